// File: rtl/axis_frame_fifo_if.sv
// AXI-stream handshake bundle shared by the frame FIFO and its neighbours.
interface axis_frame_fifo_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned USER_WIDTH = 1
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic [USER_WIDTH-1:0] tuser;

   modport master (
      output tdata,
      output tvalid,
      input  tready,
      output tlast,
      output tuser
   );

   modport slave (
      input  tdata,
      input  tvalid,
      output tready,
      input  tlast,
      input  tuser
   );
endinterface

// File: rtl/axis_frame_fifo.sv
// Store-and-forward AXI-stream frame FIFO. A frame becomes visible downstream only once its
// tlast beat is committed; bad frames (tuser[0]) and frames that do not fit are discarded.
module axis_frame_fifo #(
   parameter int unsigned ADDR_WIDTH     = 4,
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned USER_WIDTH     = 1,
   parameter bit          DROP_BAD_FRAME = 1'b1,
   parameter bit          DROP_WHEN_FULL = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   axis_frame_fifo_if.slave         s_axis,
   axis_frame_fifo_if.master        m_axis,
   output logic                     status_overflow,
   output logic                     status_bad_frame,
   output logic                     status_good_frame
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam int unsigned PTR_W = ADDR_WIDTH + 1;
   localparam logic [PTR_W-1:0] DEPTH_PTR = PTR_W'(DEPTH);

   // RAM word is {tlast, tdata}; tuser is never forwarded.
   logic [DATA_WIDTH:0] mem [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] wr_ptr_commit_q, wr_ptr_commit_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             drop_frame_q, drop_frame_d;

   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  out_last_q, out_last_d;
   logic                  out_valid_q, out_valid_d;

   logic overflow_q, overflow_d;
   logic bad_frame_q, bad_frame_d;
   logic good_frame_q, good_frame_d;

   logic empty, full, full_frame;
   logic wr_accept, wr_en, load;

   assign empty      = (rd_ptr_q == wr_ptr_commit_q);
   assign full       = ((wr_ptr_q - rd_ptr_q) == DEPTH_PTR);
   assign full_frame = ((wr_ptr_q - wr_ptr_commit_q) == DEPTH_PTR);

   // Gated by rst_n so the port reads 0 while reset is asserted. An oversized frame or a
   // frame already being dropped keeps ready high so it can be flushed.
   assign s_axis.tready = rst_n & (DROP_WHEN_FULL | ~full | full_frame | drop_frame_q);
   assign wr_accept     = s_axis.tvalid & s_axis.tready;

   assign m_axis.tdata  = out_data_q;
   assign m_axis.tvalid = out_valid_q;
   assign m_axis.tlast  = out_last_q;
   assign m_axis.tuser  = '0;

   assign status_overflow   = overflow_q;
   assign status_bad_frame  = bad_frame_q;
   assign status_good_frame = good_frame_q;

   // Write side: accept, drop or commit the incoming beat.
   always_comb begin
      wr_ptr_d        = wr_ptr_q;
      wr_ptr_commit_d = wr_ptr_commit_q;
      drop_frame_d    = drop_frame_q;
      overflow_d      = 1'b0;
      bad_frame_d     = 1'b0;
      good_frame_d    = 1'b0;
      wr_en           = 1'b0;
      if (wr_accept) begin
         if (drop_frame_q) begin
            if (s_axis.tlast) begin
               drop_frame_d = 1'b0;
               overflow_d   = 1'b1;
            end
         end else if (full || full_frame) begin
            // Rollback only touches wr_ptr; committed frames stay intact.
            wr_ptr_d = wr_ptr_commit_q;
            if (s_axis.tlast) begin
               overflow_d = 1'b1;
            end else begin
               drop_frame_d = 1'b1;
            end
         end else begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (s_axis.tlast) begin
               if (DROP_BAD_FRAME && s_axis.tuser[0]) begin
                  wr_ptr_d    = wr_ptr_commit_q;
                  bad_frame_d = 1'b1;
               end else begin
                  wr_ptr_commit_d = wr_ptr_q + 1'b1;
                  good_frame_d    = 1'b1;
               end
            end
         end
      end
   end

   // Read side: refill the output register whenever it is empty or being drained.
   always_comb begin
      load        = ~empty & (~out_valid_q | m_axis.tready);
      rd_ptr_d    = rd_ptr_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q;
      if (load) begin
         rd_ptr_d    = rd_ptr_q + 1'b1;
         {out_last_d, out_data_d} = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
         out_valid_d = 1'b1;
      end else if (m_axis.tready) begin
         out_valid_d = 1'b0;
      end
   end

   // Frame storage; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= {s_axis.tlast, s_axis.tdata};
      end
   end

   // Pointer, output and status state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q        <= '0;
         wr_ptr_commit_q <= '0;
         rd_ptr_q        <= '0;
         drop_frame_q    <= 1'b0;
         out_data_q      <= '0;
         out_last_q      <= 1'b0;
         out_valid_q     <= 1'b0;
         overflow_q      <= 1'b0;
         bad_frame_q     <= 1'b0;
         good_frame_q    <= 1'b0;
      end else begin
         wr_ptr_q        <= wr_ptr_d;
         wr_ptr_commit_q <= wr_ptr_commit_d;
         rd_ptr_q        <= rd_ptr_d;
         drop_frame_q    <= drop_frame_d;
         out_data_q      <= out_data_d;
         out_last_q      <= out_last_d;
         out_valid_q     <= out_valid_d;
         overflow_q      <= overflow_d;
         bad_frame_q     <= bad_frame_d;
         good_frame_q    <= good_frame_d;
      end
   end

endmodule

// File: doc/axis_frame_fifo.md
Name: axis_frame_fifo

Overview:
- Store-and-forward AXI-stream frame FIFO on the output of the 4-input AXI-stream arbiter mux.
- Accepts the arbitrated stream and presents a frame downstream only after its tlast beat has been written and committed.
- Discards frames flagged bad on tuser, and frames that cannot fit in the FIFO.
- Downstream logic therefore never sees a partial or errored frame.

Parameters:
- ADDR_WIDTH, 4: log2 of FIFO depth in beats (DEPTH = 2**ADDR_WIDTH = 16).
- DATA_WIDTH, 8: tdata width.
- USER_WIDTH, 1: tuser width; bit 0 is the bad-frame flag.
- DROP_BAD_FRAME, 1: 1 = discard a frame whose tlast beat carries tuser[0]=1.
- DROP_WHEN_FULL, 0: 1 = never backpressure; discard any frame that meets a full FIFO.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- input_tdata  in  DATA_WIDTH  upstream data from arbiter output.
- input_tvalid  in  1  upstream valid.
- input_tready  out  1  FIFO can accept a beat.
- input_tlast  in  1  last beat of frame.
- input_tuser  in  USER_WIDTH  sideband; bit 0 = bad frame.
- output_tdata  out  DATA_WIDTH  downstream data.
- output_tvalid  out  1  downstream valid.
- output_tready  in  1  downstream ready.
- output_tlast  out  1  last beat of frame.
- output_tuser  out  USER_WIDTH  always driven 0 (bad frames are never forwarded).
- status_overflow  out  1  one-cycle pulse: frame dropped for lack of space.
- status_bad_frame  out  1  one-cycle pulse: frame dropped by tuser.
- status_good_frame  out  1  one-cycle pulse: frame committed.

Behaviour:
- Reset:
  - Asynchronous and active-low, fixed by the arbiter subsystem's clocking; clock is clk.
  - rst_n low clears wr_ptr, wr_ptr_commit, rd_ptr, drop_frame and the output register.
  - All outputs read 0 during reset, including input_tready.
  - RAM contents are not reset.
  - Reset mid-frame discards everything, committed or not.
- Pointers:
  - Pointers are ADDR_WIDTH+1 bits and wrap naturally.
  - empty = (rd_ptr == wr_ptr_commit).
  - full = (wr_ptr - rd_ptr == DEPTH).
  - full_frame = (wr_ptr - wr_ptr_commit == DEPTH), i.e. the current frame alone fills the RAM.
- input_tready:
  - DROP_WHEN_FULL=1: always 1 out of reset.
  - DROP_WHEN_FULL=0: equals !full | full_frame | drop_frame.
- Write, on each input handshake (tvalid & tready):
  - drop_frame=1: discard the beat. On tlast, clear drop_frame and pulse status_overflow.
  - Else if full (or full_frame): roll wr_ptr back to wr_ptr_commit and discard the beat. If tlast, pulse status_overflow; otherwise set drop_frame.
  - Else: write the beat at wr_ptr[ADDR_WIDTH-1:0] and increment wr_ptr.
    - If tlast and tuser[0] and DROP_BAD_FRAME: wr_ptr <= wr_ptr_commit; pulse status_bad_frame.
    - If tlast otherwise: wr_ptr_commit <= wr_ptr+1; pulse status_good_frame.
- Read:
  - The output register loads the RAM word at rd_ptr and increments rd_ptr when !empty & (!output_tvalid | output_tready).
  - output_tvalid is set on load and cleared when output_tready & !load.
  - Full throughput: one beat per cycle sustained in both directions.
- Latency:
  - A tlast beat accepted at edge E is committed at E.
  - If the output register is free, the first beat of that frame appears (output_tvalid=1) after edge E+1.
- Simultaneous events:
  - Commit and read in the same cycle are legal; empty is evaluated on pre-edge pointers.
  - Overflow rollback never moves wr_ptr_commit.
- Pulses: status outputs are registered and last exactly one cycle.
- Data: output_tdata and output_tlast are held stable while output_tvalid & !output_tready.

Test Plan:
- Reset, then one 3-beat frame 0xA1,0xA2,0xA3 (tlast on 0xA3, tuser=0), output_tready=1:
  - output_tvalid rises 1 cycle after the tlast handshake.
  - Data out is 0xA1,0xA2,0xA3 with tlast on 0xA3.
  - status_good_frame pulses once.
- Frame 0x10,0x11 with tuser[0]=1 on tlast, then good frame 0x20:
  - Only 0x20 is emitted.
  - status_bad_frame pulses once.
  - wr_ptr equals wr_ptr_commit after the drop.
- DROP_WHEN_FULL=0, output_tready=0, 20-beat frame:
  - After 16 beats full_frame=1, input_tready stays 1 and the frame is dropped.
  - status_overflow pulses at beat 20.
  - output_tvalid never rises.
- DROP_WHEN_FULL=0, output_tready=0:
  - Two 8-beat frames fill the FIFO; input_tready=0 on the 17th beat.
  - Releasing output_tready drains 0..15 in order, and input_tready returns to 1.
- Output_tready toggling 1010 during a 10-frame stream of random lengths 1-8:
  - Output equals input order.
  - No beat is duplicated or lost.
  - tdata is held stable while stalled.
- Assert rst_n low mid-frame after 2 committed frames:
  - All outputs read 0 immediately (asynchronous).
  - After release, empty=1 and no old data emerges.
